// File: rtl/deser_pkg.sv
// Shared types and sizing for the 1:8 bit-lane deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package deser_pkg;

  localparam int N     = 8;
  localparam int SEL_W = $clog2(N);

  typedef logic [N-1:0]     word_t;
  typedef logic [SEL_W-1:0] sel_t;

  // Index of the final bit of a word; accepting it completes the word.
  localparam sel_t LAST_IDX = sel_t'(N - 1);

endpackage

// File: rtl/demux_1x8.sv
// One-hot 1-to-8 write-enable decoder; select 0 drives we[0], like the serializer mux.
// Latency: purely combinational.
// Backpressure: none; en gates every output low.
module demux_1x8 (
  input  logic       en,
  input  logic [2:0] s,
  output logic [7:0] we
);

  // Decode the select into a single asserted write enable when enabled.
  always_comb begin
    we = '0;
    if (en) begin
      we[s] = 1'b1;
    end
  end

endmodule

// File: rtl/deser_1x8.sv
// Serial-to-parallel deserializer: LSB-first bits assembled into a byte behind ready/valid.
// Latency: dout_valid rises on the edge that accepts the eighth bit.
// Backpressure: din_ready drops only on the final bit while the output slot is full and not draining.
module deser_1x8
  import deser_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sync,
  output word_t            dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] bit_idx,
  output logic             frame_err
);

  sel_t   bit_idx_q, bit_idx_d;
  word_t  asm_q, asm_d;
  word_t  dout_q, dout_d;
  logic   dout_valid_q, dout_valid_d;
  logic   frame_err_q, frame_err_d;

  logic   last_bit;
  logic   accept;
  logic   load;
  sel_t   wr_sel;
  word_t  we;

  assign last_bit = (bit_idx_q == LAST_IDX);

  // A sync abandons any final-bit stall: the pending bit restarts the frame
  // at position 0, so it must be accepted even while the slot is blocked.
  assign din_ready = sync || !(last_bit && dout_valid_q && !dout_ready);
  assign accept    = din_valid && din_ready;

  // sync steers the incoming bit to position 0 regardless of the counter.
  assign wr_sel = sync ? '0 : bit_idx_q;

  // A word completes only on a non-sync accept of the final bit.
  assign load = accept && last_bit && !sync;

  demux_1x8 u_demux (
    .en (accept),
    .s  (wr_sel),
    .we (we)
  );

  // Write the accepted bit into the assembly register at the decoded position.
  always_comb begin
    asm_d = asm_q;
    for (int i = 0; i < N; i++) begin
      if (we[i]) begin
        asm_d[i] = din;
      end
    end
  end

  // Next-state for the bit counter, output slot and frame error pulse.
  always_comb begin
    bit_idx_d = bit_idx_q;
    if (sync) begin
      bit_idx_d = accept ? sel_t'(1) : '0;
    end else if (accept) begin
      bit_idx_d = last_bit ? '0 : bit_idx_q + sel_t'(1);
    end

    // asm_d already carries the final bit in position N-1.
    dout_d       = load ? asm_d : dout_q;
    dout_valid_d = load || (dout_valid_q && !dout_ready);

    frame_err_d  = sync && (bit_idx_q != '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_q    <= '0;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_idx_q    <= bit_idx_d;
      asm_q        <= asm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bit_idx    = bit_idx_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/deser_1x8.md
# deser_1x8

Serial-to-parallel deserializer: accepts one bit per handshake, steers each bit through a 1-to-8 demux into the bit position given by an internal 3-bit index counter, and presents the assembled byte on a ready/valid output. It is the receive-side counterpart of the 8:1 mux serializer used on the same bit lane. Bit order is LSB first: the first bit accepted after alignment lands in `dout[0]`, matching the mux convention that select 0 routes `i[0]`.

## Interface
- `N`, 8, word width in bits; fixed at 8 for this release.
- `SEL_W`, 3, index counter width, `$clog2(N)`.

- `clk`  in  1  rising-edge clock; only clock.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block accepts `din` this cycle.
- `sync`  in  1  frame alignment; restarts assembly at bit 0.
- `dout`  out  N  assembled word.
- `dout_valid`  out  1  `dout` holds an undelivered word.
- `dout_ready`  in  1  consumer takes `dout` this cycle.
- `bit_idx`  out  SEL_W  current demux select, i.e. the position of the next accepted bit.
- `frame_err`  out  1  one-cycle pulse: partial word discarded by `sync`.

## Operation
- Accept condition: `din_valid && din_ready`.
- `din_ready = !(bit_idx == N-1 && dout_valid && !dout_ready)`. The block stalls only on the final bit while the output slot is occupied and not draining.
- On accept with `bit_idx < N-1`: `asm[bit_idx] <= din`, then `bit_idx <= bit_idx + 1`. The write enable is the one-hot demux decode of `bit_idx`.
- On accept with `bit_idx == N-1`:
  - `dout <= {din, asm[N-2:0]}`
  - `dout_valid <= 1`
  - `bit_idx <= 0`
  - `asm` is not cleared.
- Output slot: `dout_valid` clears on `dout_ready` unless a new word loads in the same cycle; in that case it stays 1 with the new data. `dout` holds its value while `dout_valid && !dout_ready`.
- `sync` has priority over the counter:
  - `bit_idx` is forced to 0.
  - If `din` is also accepted that cycle, it is written to `asm[0]` and `bit_idx <= 1`.
  - If `bit_idx != 0` when `sync` is seen, `frame_err` pulses for one cycle.
  - The output slot is unaffected.
- `sync` on the bit-7 stall cycle: the stall is abandoned, the pending bit (if valid) goes to position 0, and `frame_err` pulses.
- `bit_idx` wraps 7 → 0 only via word completion or `sync`; no other wrap.

## Timing
- Reset values:
  - `bit_idx` = 0
  - `asm` = 0
  - `dout` = 0
  - `dout_valid` = 0
  - `frame_err` = 0
  - `din_ready` = 1 (combinational on reset state)
- Reset mid-word discards the partial word and any undelivered `dout` without asserting `frame_err`.
- Latency: `dout_valid` rises on the clock edge that accepts bit 7, so it is visible the cycle after that accept.
- Throughput: one bit per cycle sustained; one word every 8 accepted bits when `dout_ready` is high.
- `din_ready` depends combinationally on `dout_ready`. There is no combinational path from `din` or `din_valid` to any output.
- `frame_err` is registered and lasts exactly one cycle per offending `sync`.

## Structure
- Shared package `deser_pkg`: `N`, `SEL_W`, and typedef `word_t` (`logic [N-1:0]`).
- Sub-module `demux_1x8`: combinational 1-to-8 decoder with inputs `en`, `s[2:0]` and output `we[7:0]` (one-hot write enable). It mirrors the serializer's mux select decode.
- Top level holds the counter, the assembly register, the output slot, and the handshake logic.

## Test plan
- Reset, then 8 accepted bits 1,0,1,1,0,0,1,0 with `dout_ready` = 1 → `dout` = 8'h4D, `dout_valid` high for one cycle, `bit_idx` back to 0.
- Two back-to-back words 8'hA5 and 8'h3C (LSB first) at one bit per cycle → both delivered in order, no `din_ready` deassert.
- Word 8'hFF delivered with `dout_ready` = 0, then a second word streamed → `din_ready` drops at `bit_idx` = 7. Raising `dout_ready` takes 8'hFF, the 8th bit is accepted, and the next `dout` is the second word.
- After 5 bits, `sync` together with a valid bit 1 → `frame_err` pulses once, `bit_idx` = 1, and the next 7 bits complete a word whose `dout[0]` = 1.
- `rst` asserted at `bit_idx` = 4 while `dout_valid` = 1 → next cycle all outputs are at reset values and `frame_err` = 0.
- `din_valid` toggling 1,0,1,0 across a full word → the word completes after 8 accepts (16 cycles) with the correct value.
